// File: rtl/booth_acc_pkg.sv
// booth_acc_pkg: shared FSM state type, product width and a width-parameterised saturating adder
package booth_acc_pkg;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [32:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    logic signed [33:0] s, hi, lo;
    s = 34'(a) + 34'(b);
    hi = (34'sd1 <<< (w - 1)) - 34'sd1;
    lo = -hi - 34'sd1;
    return s > hi ? {1'b1, hi[31:0]} : s < lo ? {1'b1, lo[31:0]} : {1'b0, s[31:0]};
  endfunction
endpackage

// File: rtl/booth_product_accumulator_delay.sv
// valid_delay_line: DEPTH-stage shift register (clk, rst, d in; q out = d delayed DEPTH cycles)
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk) sr <= rst ? '0 : DEPTH'({sr, d});
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums LEN aligned products with saturation (in: start, op_valid, product, sum_ready; out: sum, sum_valid, busy, overflow, lost)
module booth_product_accumulator
  import booth_acc_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int LEN = 4,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_valid,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              overflow,
  output logic              lost
);
  localparam int CW = $clog2(LEN + 1);
  state_t state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] sum_n;
  logic [CW-1:0] count, count_n;
  logic ovf_n, pvalid, last;
  logic [32:0] sa;
  valid_delay_line #(.DEPTH(MULT_LATENCY)) u_dly (.clk(clk), .rst(rst), .d(op_valid), .q(pvalid));
  assign sa = sat_add(32'(acc), 32'(signed'(product)), ACC_W);
  assign last = count == CW'(LEN - 1);
  always_comb begin
    state_n = state;
    acc_n = acc;
    count_n = count;
    sum_n = sum;
    ovf_n = overflow;
    if (state == IDLE && start) begin
      state_n = ACCUM;
      acc_n = '0;
      count_n = '0;
      ovf_n = 1'b0;
    end
    if (state == ACCUM && pvalid) begin
      acc_n = sa[ACC_W-1:0];
      count_n = count + 1'b1;
      ovf_n = overflow | sa[32];
      state_n = last ? DONE : ACCUM;
      sum_n = last ? sa[ACC_W-1:0] : sum;
    end
    if (state == DONE && sum_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      sum <= '0;
      overflow <= 1'b0;
      lost <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      count <= count_n;
      sum <= sum_n;
      overflow <= ovf_n;
      lost <= pvalid && state != ACCUM;
    end
  end
  assign sum_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: scoreboard bench driving three accumulator configurations through a behavioural multiplier
module tb_booth_product_accumulator;
  logic clk = 0, rst = 1, op_valid = 0;
  logic start0 = 0, start1 = 0, start2 = 0, rdy0 = 1, rdy1 = 1, rdy2 = 1;
  logic [15:0] product;
  logic [15:0] pipe [4];
  int a = 0, b = 0;
  logic [23:0] sum0, sum2;
  logic [15:0] sum1;
  logic sv0, sv1, sv2, busy0, busy1, busy2, ovf0, ovf1, ovf2, lost0, lost1, lost2;
  int checks = 0, errors = 0, sv2_cnt = 0;
  logic [32:0] q0[$], q1[$], q2[$];

  booth_product_accumulator #(.MULT_LATENCY(4), .LEN(4), .ACC_W(24)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op_valid(op_valid), .product(product),
    .sum(sum0), .sum_valid(sv0), .sum_ready(rdy0), .busy(busy0), .overflow(ovf0), .lost(lost0));
  booth_product_accumulator #(.MULT_LATENCY(4), .LEN(4), .ACC_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op_valid(op_valid), .product(product),
    .sum(sum1), .sum_valid(sv1), .sum_ready(rdy1), .busy(busy1), .overflow(ovf1), .lost(lost1));
  booth_product_accumulator #(.MULT_LATENCY(4), .LEN(1), .ACC_W(24)) u2 (
    .clk(clk), .rst(rst), .start(start2), .op_valid(op_valid), .product(product),
    .sum(sum2), .sum_valid(sv2), .sum_ready(rdy2), .busy(busy2), .overflow(ovf2), .lost(lost2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= 16'(a * b);
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign product = pipe[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sv2) sv2_cnt++;
      if (sv0 && rdy0) begin
        if (q0.size() == 0) chk("q0_extra", 1, 0);
        else chk("sum0", {ovf0, 32'(signed'(sum0))}, q0.pop_front());
      end
      if (sv1 && rdy1) begin
        if (q1.size() == 0) chk("q1_extra", 1, 0);
        else chk("sum1", {ovf1, 32'(signed'(sum1))}, q1.pop_front());
      end
      if (sv2 && rdy2) begin
        if (q2.size() == 0) chk("q2_extra", 1, 0);
        else chk("sum2", {ovf2, 32'(signed'(sum2))}, q2.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int inst);
    return inst == 0 ? busy0 : inst == 1 ? busy1 : busy2;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else if (inst == 1) start1 = v;
    else start2 = v;
  endtask

  task automatic ops(input int inst, input int n, input int av[4], input int bv[4], input bit push);
    longint s = 0, hi, lo;
    bit o = 0;
    int w = inst == 1 ? 16 : 24;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    for (int i = 0; i < n; i++) begin
      a = av[i];
      b = bv[i];
      op_valid = 1;
      s += longint'(av[i] * bv[i]);
      if (s > hi) begin s = hi; o = 1; end
      else if (s < lo) begin s = lo; o = 1; end
      tick;
    end
    op_valid = 0;
    a = 0;
    b = 0;
    if (push) begin
      if (inst == 0) q0.push_back({o, 32'(s)});
      else if (inst == 1) q1.push_back({o, 32'(s)});
      else q2.push_back({o, 32'(s)});
    end
  endtask

  task automatic frame(input int inst, input int n, input int av[4], input int bv[4]);
    set_start(inst, 1);
    tick;
    set_start(inst, 0);
    ops(inst, n, av, bv, 1);
  endtask

  task automatic wait_idle(input int inst);
    int n = 0;
    do begin tick; n++; end while (busy_of(inst) && n < 60);
    chk("idle_timeout", busy_of(inst), 0);
  endtask

  initial begin
    int n;
    bit ls;
    tick;
    tick;
    chk("rst_sum", sum0, 0);
    chk("rst_sv", sv0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_lost", lost0, 0);
    rst = 0;
    tick;
    frame(0, 4, '{2, -4, 36, -127}, '{4, 5, -8, -127});
    n = 0;
    while (!sv0 && n < 20) begin tick; n++; end
    chk("latency", n, 4);
    chk("t1_ovf", ovf0, 0);
    wait_idle(0);
    frame(1, 4, '{127, 127, 127, 0}, '{127, 127, 127, 0});
    wait_idle(1);
    frame(1, 4, '{-128, -128, -128, 0}, '{128, 128, 128, 0});
    wait_idle(1);
    chk("ovf_hold", ovf1, 1);
    rdy0 = 0;
    frame(0, 4, '{3, -7, 100, 1}, '{9, 11, 50, -1});
    n = 0;
    while (!sv0 && n < 20) begin tick; n++; end
    chk("bp_rise", sv0, 1);
    start0 = 1;
    op_valid = 1;
    a = 6;
    b = 6;
    tick;
    start0 = 0;
    op_valid = 0;
    a = 0;
    b = 0;
    ls = 0;
    for (int k = 0; k < 7; k++) begin
      chk("bp_sv", sv0, 1);
      chk("bp_busy", busy0, 1);
      chk("bp_sum", sum0, 4949);
      ls |= lost0;
      tick;
    end
    ls |= lost0;
    chk("bp_lost", ls, 1);
    chk("bp_ovf", ovf0, 0);
    rdy0 = 1;
    wait_idle(0);
    start0 = 1;
    tick;
    start0 = 0;
    ops(0, 2, '{8, 9, 0, 0}, '{8, 9, 0, 0}, 0);
    repeat (4) tick;
    chk("mid_busy", busy0, 1);
    rst = 1;
    tick;
    chk("mid_sum", sum0, 0);
    chk("mid_sv", sv0, 0);
    chk("mid_busy0", busy0, 0);
    chk("mid_ovf", ovf0, 0);
    chk("mid_lost", lost0, 0);
    rst = 0;
    tick;
    frame(0, 4, '{2, -4, 36, -127}, '{4, 5, -8, -127});
    wait_idle(0);
    op_valid = 1;
    a = 7;
    b = 7;
    tick;
    op_valid = 0;
    a = 0;
    b = 0;
    n = 0;
    while (!lost0 && n < 10) begin
      chk("idle_busy", busy0, 0);
      tick;
      n++;
    end
    chk("lost_lat", n, 4);
    tick;
    chk("lost_pulse", lost0, 0);
    op_valid = 1;
    a = 7;
    b = 7;
    tick;
    op_valid = 0;
    a = 0;
    b = 0;
    repeat (3) tick;
    start0 = 1;
    tick;
    start0 = 0;
    chk("lost_start", lost0, 1);
    chk("busy_start", busy0, 1);
    ops(0, 4, '{1, 1, 1, 1}, '{1, 2, 3, 4}, 1);
    wait_idle(0);
    for (int f = 0; f < 3; f++) begin
      frame(2, 1, '{-4, 0, 0, 0}, '{5, 0, 0, 0});
      wait_idle(2);
      repeat (3) tick;
    end
    chk("len1_sv", sv2_cnt, 3);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
